// File: rtl/dbg_snapshot_serializer.sv
// Debug snapshot serializer: captures every pipeline-latch debug word in one edge,
// then streams either all words or one selected word out byte-by-byte over valid/ready.
module dbg_snapshot_serializer #(
    parameter int NUM_WORDS = 24,
    parameter int WORD_W    = 32,
    parameter int SEL_W     = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] in_words,
    input  logic                        in_start,
    input  logic                        in_mode,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_ready,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_word,
    output logic                        out_busy,
    output logic                        out_done,
    output logic                        out_err
);
    localparam int BYTES  = WORD_W / 8;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE, ERR} state_t;

    state_t state, nextState;

    logic [NUM_WORDS-1:0][WORD_W-1:0] snap;
    logic [IDX_W-1:0]                 wordIdx, lastIdx;
    logic [BIDX_W-1:0]                byteIdx;
    logic [WORD_W-1:0]                curWord;
    logic                             selBad, lastByte, lastWord, xfer, accept;

    // Extra compare bit keeps the range check correct when NUM_WORDS == 2**SEL_W.
    assign selBad   = in_mode && ({1'b0, in_sel} >= (SEL_W+1)'(NUM_WORDS));
    assign accept   = (state == IDLE) && in_start && !selBad;
    assign curWord  = snap[wordIdx];
    assign lastByte = (byteIdx == BIDX_W'(BYTES - 1));
    assign lastWord = (wordIdx == lastIdx);
    assign xfer     = (state == SEND) && in_ready;

    assign out_valid = (state == SEND);
    assign out_busy  = (state != IDLE);
    assign out_done  = (state == DONE);
    assign out_err   = (state == ERR);
    assign out_word  = curWord;
    assign out_byte  = out_valid ? curWord[{byteIdx, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (in_start) nextState = selBad ? ERR : SEND;
            end
            SEND: begin
                if (xfer && lastByte && lastWord) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Indices are left untouched after the final byte so out_word keeps showing it in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap    <= '0;
            wordIdx <= '0;
            lastIdx <= '0;
            byteIdx <= '0;
        end else if (accept) begin
            snap    <= in_words;
            wordIdx <= in_mode ? in_sel[IDX_W-1:0] : '0;
            lastIdx <= in_mode ? in_sel[IDX_W-1:0] : IDX_W'(NUM_WORDS - 1);
            byteIdx <= '0;
        end else if (xfer) begin
            if (!lastByte) begin
                byteIdx <= byteIdx + BIDX_W'(1);
            end else if (!lastWord) begin
                wordIdx <= wordIdx + IDX_W'(1);
                byteIdx <= '0;
            end
        end
    end
endmodule
